perceptron_infer_stream: RTL and testbench

Streaming inference engine for the single-layer perceptron. It consumes a trained parameter set as a serial word stream: INPUT_UNITS weights followed by one bias. It then classifies input vectors arriving one element per beat over a valid/ready handshake. Each result is emitted as a raw weighted sum and an activated prediction. The block sits downstream of perceptron training and turns a learned weight set into a classification pipeline stage.

---
 rtl/perceptron_infer_stream.sv | 201 ++++++++++++++++++++
 tb/tb_perceptron_infer_stream.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/perceptron_infer_stream.sv
`default_nettype none
// ============================================================================
// Module      : perceptron_infer_stream
// Description : Streaming single-layer perceptron inference. Loads N weights
//               plus a bias serially, then classifies N-element input vectors.
// Revision    : 1.0 - initial release
// ============================================================================
module perceptron_infer_stream #(
    parameter int INPUT_UNITS = 2,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic [31:0]      load_data,
    input  logic             act_sel,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_sum,
    output logic [31:0]      out_pred,
    output logic             weights_valid,
    output logic [CNT_W-1:0] samples_done
);

    localparam int c_load_w = $clog2(INPUT_UNITS + 1);
    localparam int c_idx_w  = (INPUT_UNITS > 1) ? $clog2(INPUT_UNITS) : 1;

    localparam logic [c_load_w-1:0] c_load_last = c_load_w'(INPUT_UNITS);
    localparam logic [c_load_w-1:0] c_load_one  = c_load_w'(1);
    localparam logic [c_idx_w-1:0]  c_elem_last = c_idx_w'(INPUT_UNITS - 1);
    localparam logic [c_idx_w-1:0]  c_elem_one  = c_idx_w'(1);
    localparam logic [CNT_W-1:0]    c_cnt_one   = CNT_W'(1);

    typedef enum logic [1:0] {
        ST_EMPTY  = 2'd0,
        ST_IDLE   = 2'd1,
        ST_ACCUM  = 2'd2,
        ST_OUTPUT = 2'd3
    } state_t;

    state_t                r_state;
    state_t                w_next_state;
    logic [31:0]           r_weights [INPUT_UNITS];
    logic [31:0]           r_bias;
    logic [c_load_w-1:0]   r_load_idx;
    logic [c_idx_w-1:0]    r_elem_idx;
    logic [31:0]           r_acc;
    logic [31:0]           r_out_sum;
    logic [31:0]           r_out_pred;
    logic                  r_weights_valid;
    logic [CNT_W-1:0]      r_samples_done;

    logic                  w_load_ready;
    logic                  w_in_ready;
    logic                  w_out_valid;
    logic                  w_load_fire;
    logic                  w_in_fire;
    logic                  w_out_fire;
    logic                  w_load_bias;
    logic                  w_last;
    logic                  w_idle_accept;
    logic [31:0]           w_weight;
    logic [31:0]           w_prod;
    logic [31:0]           w_sum;
    logic [31:0]           w_act;

    assign w_load_bias   = (r_load_idx == c_load_last);
    assign w_last        = (r_elem_idx == c_elem_last);
    assign w_idle_accept = r_weights_valid && (r_load_idx == '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_EMPTY;
        end else begin
            r_state <= w_next_state;
        end
    end

    // A sample already in ACCUM always runs to completion: a load whose first
    // beat coincided with sample beat 0 is paused by load_ready=0, so the
    // remaining old weights stay intact for the rest of that sample.
    always_comb begin
        w_next_state = r_state;
        w_load_ready = 1'b0;
        w_in_ready   = 1'b0;
        w_out_valid  = 1'b0;
        case (r_state)
            ST_EMPTY: begin
                w_load_ready = 1'b1;
                if (load_valid && w_load_bias) begin
                    w_next_state = ST_IDLE;
                end
            end
            ST_IDLE: begin
                w_load_ready = 1'b1;
                w_in_ready   = w_idle_accept;
                if (in_valid && w_idle_accept) begin
                    w_next_state = w_last ? ST_OUTPUT : ST_ACCUM;
                end
            end
            ST_ACCUM: begin
                w_in_ready = 1'b1;
                if (in_valid && w_last) begin
                    w_next_state = ST_OUTPUT;
                end
            end
            ST_OUTPUT: begin
                w_out_valid = 1'b1;
                if (out_ready) begin
                    w_next_state = ST_IDLE;
                end
            end
            default: begin
                w_next_state = ST_EMPTY;
            end
        endcase
    end

    assign w_load_fire = load_valid && w_load_ready;
    assign w_in_fire   = in_valid && w_in_ready;
    assign w_out_fire  = w_out_valid && out_ready;

    always_comb begin
        w_weight = '0;
        for (int i = 0; i < INPUT_UNITS; i++) begin
            if (r_elem_idx == c_idx_w'(i)) begin
                w_weight = r_weights[i];
            end
        end
    end

    // Low 32 bits of the product are identical for signed and unsigned operands.
    assign w_prod = w_weight * in_data;
    assign w_sum  = ((r_elem_idx == '0) ? r_bias : r_acc) + w_prod;
    assign w_act  = act_sel ? w_sum : {31'd0, ~w_sum[31]};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < INPUT_UNITS; i++) begin
                r_weights[i] <= '0;
            end
            r_bias          <= '0;
            r_load_idx      <= '0;
            r_weights_valid <= 1'b0;
        end else if (w_load_fire) begin
            if (w_load_bias) begin
                r_bias          <= load_data;
                r_load_idx      <= '0;
                r_weights_valid <= 1'b1;
            end else begin
                for (int i = 0; i < INPUT_UNITS; i++) begin
                    if (r_load_idx == c_load_w'(i)) begin
                        r_weights[i] <= load_data;
                    end
                end
                r_load_idx <= r_load_idx + c_load_one;
                if (r_load_idx == '0) begin
                    r_weights_valid <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_elem_idx     <= '0;
            r_acc          <= '0;
            r_out_sum      <= '0;
            r_out_pred     <= '0;
            r_samples_done <= '0;
        end else begin
            if (w_in_fire) begin
                r_acc <= w_sum;
                if (w_last) begin
                    r_out_sum  <= w_sum;
                    r_out_pred <= w_act;
                    r_elem_idx <= '0;
                end else begin
                    r_elem_idx <= r_elem_idx + c_elem_one;
                end
            end
            if (w_out_fire) begin
                r_samples_done <= r_samples_done + c_cnt_one;
            end
        end
    end

    assign load_ready    = w_load_ready;
    assign in_ready      = w_in_ready;
    assign out_valid     = w_out_valid;
    assign out_sum       = r_out_sum;
    assign out_pred      = r_out_pred;
    assign weights_valid = r_weights_valid;
    assign samples_done  = r_samples_done;

endmodule
`default_nettype wire

// File: tb/tb_perceptron_infer_stream.sv
`default_nettype none
// ============================================================================
// Module      : tb_perceptron_infer_stream
// Description : Self-checking bench for perceptron_infer_stream (N = 2).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_perceptron_infer_stream;

    localparam int c_n     = 2;
    localparam int c_cnt_w = 16;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               load_valid = 1'b0;
    logic               load_ready;
    logic [31:0]        load_data = '0;
    logic               act_sel = 1'b0;
    logic               in_valid = 1'b0;
    logic               in_ready;
    logic [31:0]        in_data = '0;
    logic               out_valid;
    logic               out_ready = 1'b0;
    logic [31:0]        out_sum;
    logic [31:0]        out_pred;
    logic               weights_valid;
    logic [c_cnt_w-1:0] samples_done;

    int n_checks = 0;
    int n_errors = 0;

    int model_w [c_n];
    int model_b;
    int exp_done = 0;

    perceptron_infer_stream #(.INPUT_UNITS(c_n), .CNT_W(c_cnt_w)) dut (
        .clk           (clk),
        .rst           (rst),
        .load_valid    (load_valid),
        .load_ready    (load_ready),
        .load_data     (load_data),
        .act_sel       (act_sel),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_data       (in_data),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_sum       (out_sum),
        .out_pred      (out_pred),
        .weights_valid (weights_valid),
        .samples_done  (samples_done)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_load_ready"}, load_ready, 1);
        check_eq({tag, "_in_ready"}, in_ready, 0);
        check_eq({tag, "_out_valid"}, out_valid, 0);
        check_eq({tag, "_out_sum"}, out_sum, 0);
        check_eq({tag, "_out_pred"}, out_pred, 0);
        check_eq({tag, "_weights_valid"}, weights_valid, 0);
        check_eq({tag, "_samples_done"}, samples_done, 0);
    endtask

    task automatic load_word(input logic [31:0] d);
        int t = 0;
        @(negedge clk);
        load_valid = 1'b1;
        load_data  = d;
        while (!load_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        check_eq("load_ready_wait", load_ready, 1);
        @(posedge clk);
        #1 load_valid = 1'b0;
    endtask

    task automatic send_elem(input logic [31:0] x, input logic act);
        int t = 0;
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = x;
        act_sel  = act;
        while (!in_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        check_eq("in_ready_wait", in_ready, 1);
        @(posedge clk);
        #1 in_valid = 1'b0;
        act_sel = ~act;
    endtask

    task automatic load_params(input int w0, input int w1, input int b);
        load_word(w0);
        check_eq("wv_mid_load", weights_valid, 0);
        check_eq("in_ready_mid_load", in_ready, 0);
        load_word(w1);
        check_eq("wv_before_bias", weights_valid, 0);
        load_word(b);
        model_w[0] = w0;
        model_w[1] = w1;
        model_b    = b;
        check_eq("wv_after_bias", weights_valid, 1);
        check_eq("in_ready_after_bias", in_ready, 1);
    endtask

    task automatic run_sample(input int x0, input int x1, input logic act, input int hold);
        int          t = 0;
        int          s;
        logic [31:0] exp_sum;
        logic [31:0] exp_pred;
        logic [31:0] prev_done;
        s        = model_b + model_w[0] * x0 + model_w[1] * x1;
        exp_sum  = s;
        exp_pred = act ? s : ((s >= 0) ? 1 : 0);
        send_elem(x0, ~act);
        check_eq("out_valid_early", out_valid, 0);
        send_elem(x1, act);
        check_eq("out_valid_latency", out_valid, 1);
        @(negedge clk);
        while (!out_valid && t < 50) begin
            @(negedge clk);
            t++;
        end
        check_eq("out_valid_wait", out_valid, 1);
        check_eq("out_sum", out_sum, exp_sum);
        check_eq("out_pred", out_pred, exp_pred);
        prev_done = samples_done;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check_eq("hold_valid", out_valid, 1);
            check_eq("hold_sum", out_sum, exp_sum);
            check_eq("hold_pred", out_pred, exp_pred);
            check_eq("hold_in_ready", in_ready, 0);
            check_eq("hold_load_ready", load_ready, 0);
            check_eq("hold_done", samples_done, prev_done);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
        exp_done = (exp_done + 1) % (1 << c_cnt_w);
        check_eq("samples_done", samples_done, exp_done);
        check_eq("out_valid_cleared", out_valid, 0);
        check_eq("in_ready_after_out", in_ready, 1);
    endtask

    function automatic int rand_word();
        if ($urandom_range(0, 3) == 0) begin
            return int'($urandom);
        end
        return int'($urandom_range(0, 400)) - 200;
    endfunction

    initial begin
        model_w = '{0, 0};
        model_b = 0;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b0;
        @(negedge clk);
        check_eq("in_ready_empty", in_ready, 0);

        load_params(2, -3, 1);
        run_sample(4, 1, 1'b0, 0);
        run_sample(0, 1, 1'b0, 0);
        run_sample(0, 0, 1'b1, 0);
        run_sample(-5, 2, 1'b0, 5);

        load_params(32'h7FFF_FFFF, 0, 0);
        run_sample(2, 5, 1'b0, 0);

        load_params(-1, -1, 0);
        run_sample(3, 4, 1'b0, 0);

        for (int k = 0; k < 25; k++) begin
            if ($urandom_range(0, 3) == 0) begin
                load_params(rand_word(), rand_word(), rand_word());
            end
            run_sample(rand_word(), rand_word(), 1'($urandom_range(0, 1)), int'($urandom_range(0, 3)));
        end

        send_elem(7, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check_reset_outputs("mid_sample_reset");
        exp_done = 0;
        @(negedge clk);
        rst = 1'b0;
        in_valid = 1'b1;
        in_data  = 9;
        repeat (3) begin
            @(negedge clk);
            check_eq("in_ready_post_reset", in_ready, 0);
        end
        in_valid = 1'b0;
        load_params(5, 6, -10);
        run_sample(1, 2, 1'b1, 0);
        run_sample(-3, 1, 1'b0, 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
